// File: rtl/bcminer_pkg.sv
// Shared types for the miner result path: nonce word and collector FSM states.
// Consumed by nonce_collector and nonce_fifo via import bcminer_pkg::*.
package bcminer_pkg;

  typedef logic [31:0] nonce_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_REPORT
  } collector_state_e;

endpackage

// File: rtl/nonce_collector_if.sv
// Beat stream from the last lattice block plus the nonce pop handshake.
// The slave modport is the collector's view; master is the producer/consumer side.
interface nonce_collector_if #(
  parameter int NUM_CORES = 10
);
  localparam int CORE_W = $clog2(NUM_CORES);

  logic              valid_i;
  logic              newblock_i;
  logic              done_i;
  logic              hit_i;
  logic [CORE_W-1:0] core_i;
  logic [31-CORE_W:0] count_i;
  logic [31:0]       nonce_o;
  logic              nonce_valid_o;
  logic              nonce_ready_i;

  modport slave (
    input  valid_i, newblock_i, done_i, hit_i, core_i, count_i, nonce_ready_i,
    output nonce_o, nonce_valid_o
  );

  modport master (
    output valid_i, newblock_i, done_i, hit_i, core_i, count_i, nonce_ready_i,
    input  nonce_o, nonce_valid_o
  );
endinterface

// File: rtl/nonce_fifo.sv
// Power-of-two nonce FIFO with flush; the caller only pushes when space exists
// (or a pop/flush frees it in the same cycle). Head reads as zero when empty.
module nonce_fifo
  import bcminer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  nonce_t din,
  output nonce_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  nonce_t      mem_q [DEPTH];
  nonce_t      mem_d [DEPTH];
  logic        do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // A flush restarts both pointers, so a push in the same cycle lands in slot 0.
  always_comb begin
    do_pop = pop && !empty && !flush;
    wr_d   = wr_q;
    rd_d   = rd_q;
    mem_d  = mem_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_d[AW-1:0]] = din;
      wr_d = wr_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nonce_collector.sv
// Collects winning nonces from lattice result beats, tracks sweep status and queues hits.
// Optional NONCE_COLLECTOR_DEDUP_EN drops a hit repeating the last accepted nonce of the sweep.
module nonce_collector
  import bcminer_pkg::*;
#(
  parameter int NUM_CORES  = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int HIT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  nonce_collector_if.slave bus,
  output logic             result_valid_o,
  output logic             success_o,
  output logic             overflow_o,
  output logic [HIT_W-1:0] hit_count_o
);

  collector_state_e state_q, state_d;
  logic             success_q, success_d;
  logic             overflow_q, overflow_d;
  logic [HIT_W-1:0] hit_count_q, hit_count_d;

  logic   new_beat;
  logic   sweep_beat;
  logic   want_push;
  logic   push_ok;
  logic   flush;
  logic   pop;
  nonce_t nonce_in;
  nonce_t fifo_dout;
  logic   fifo_full;
  logic   fifo_empty;

`ifdef NONCE_COLLECTOR_DEDUP_EN
  nonce_t last_nonce_q, last_nonce_d;
  logic   last_valid_q, last_valid_d;
`endif

  assign new_beat   = bus.valid_i && bus.newblock_i;
  assign sweep_beat = bus.valid_i && !bus.newblock_i && (state_q == ST_SWEEP);
  assign flush      = new_beat && (state_q == ST_SWEEP);
  assign nonce_in   = {bus.count_i, bus.core_i};
  assign pop        = !fifo_empty && bus.nonce_ready_i;

  // A newblock beat opens a fresh sweep, so it never matches a stale last nonce.
`ifdef NONCE_COLLECTOR_DEDUP_EN
  assign want_push = (new_beat || sweep_beat) && bus.hit_i &&
                     !(last_valid_q && !new_beat && (last_nonce_q == nonce_in));
`else
  assign want_push = (new_beat || sweep_beat) && bus.hit_i;
`endif

  assign push_ok = want_push && (flush || !fifo_full || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (new_beat) state_d = bus.done_i ? ST_REPORT : ST_SWEEP;
      end
      ST_SWEEP: begin
        if (bus.valid_i && bus.done_i) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (new_beat) state_d = bus.done_i ? ST_REPORT : ST_SWEEP;
        else          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep statistics restart on every newblock beat, then absorb that beat's own hit.
  always_comb begin
    success_d   = success_q;
    overflow_d  = overflow_q;
    hit_count_d = hit_count_q;
    if (new_beat) begin
      success_d   = 1'b0;
      overflow_d  = 1'b0;
      hit_count_d = '0;
    end
    if (want_push) success_d = 1'b1;
    if (want_push && !push_ok) overflow_d = 1'b1;
    if (push_ok && (hit_count_d != {HIT_W{1'b1}})) hit_count_d = hit_count_d + 1'b1;
  end

`ifdef NONCE_COLLECTOR_DEDUP_EN
  always_comb begin
    last_nonce_d = last_nonce_q;
    last_valid_d = last_valid_q;
    if (new_beat) last_valid_d = 1'b0;
    if (push_ok) begin
      last_nonce_d = nonce_in;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_nonce_q <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_nonce_q <= last_nonce_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      success_q   <= 1'b0;
      overflow_q  <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      success_q   <= success_d;
      overflow_q  <= overflow_d;
      hit_count_q <= hit_count_d;
    end
  end

  nonce_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_ok),
    .pop  (pop),
    .flush(flush),
    .din  (nonce_in),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign result_valid_o    = (state_q == ST_REPORT);
  assign success_o         = success_q;
  assign overflow_o        = overflow_q;
  assign hit_count_o       = hit_count_q;
  assign bus.nonce_o       = fifo_dout;
  assign bus.nonce_valid_o = !fifo_empty;

endmodule

// File: doc/nonce_collector.md
NONCE_COLLECTOR -- requirements
Module: nonce_collector

Interface
REQ-001 SHALL have parameter NUM_CORES, default 10: core count in the lattice; CORE_W = $clog2(NUM_CORES).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: nonce FIFO entries, power of two, 2..64.
REQ-003 SHALL have parameter HIT_W, default 8: width of the saturating hit counter.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 valid_i  in  1  result beat from the last lattice block is valid.
REQ-007 newblock_i  in  1  beat is the first of a new block sweep; qualified by valid_i.
REQ-008 done_i  in  1  beat is the last of the sweep; qualified by valid_i.
REQ-009 hit_i  in  1  beat carries a winning hash; qualified by valid_i.
REQ-010 core_i  in  CORE_W  index of the core that produced the beat.
REQ-011 count_i  in  32-CORE_W  per-core nonce counter of the beat.
REQ-012 result_valid_o  out  1  one-cycle pulse: sweep complete.
REQ-013 success_o  out  1  at least one hit accepted in the completed sweep; meaningful with result_valid_o.
REQ-014 nonce_o  out  32  FIFO head nonce.
REQ-015 nonce_valid_o  out  1  FIFO non-empty.
REQ-016 nonce_ready_i  in  1  consumer pops head when nonce_valid_o && nonce_ready_i.
REQ-017 overflow_o  out  1  sticky: a hit was dropped this sweep.
REQ-018 hit_count_o  out  HIT_W  accepted hits this sweep, saturating at 2^HIT_W-1.

Function
REQ-019 Nonce SHALL be reconstructed as {count_i, core_i}.
REQ-020 FSM states IDLE, SWEEP, REPORT: IDLE->SWEEP on valid_i&&newblock_i; SWEEP->REPORT on valid_i&&done_i; REPORT->IDLE unconditionally after one cycle, or REPORT->SWEEP if valid_i&&newblock_i in REPORT.
REQ-021 Beats are ignored in IDLE unless newblock_i; a beat with newblock_i&&done_i is a complete one-beat sweep.
REQ-022 A hit beat in cycle N (in SWEEP, or the newblock beat itself) SHALL push its nonce; nonce_valid_o rises at N+1 when the FIFO was empty.
REQ-023 done_i beat in cycle N SHALL produce result_valid_o=1 in cycle N+1 only; success_o includes a hit on the done beat.
REQ-024 newblock_i while in SWEEP SHALL abort the sweep: flush FIFO, clear hit_count_o, overflow_o and success tracking, no result_valid_o for the aborted sweep; the newblock beat's own hit is then pushed into the empty FIFO.
REQ-025 Full FIFO with push and no pop: hit dropped, overflow_o set next cycle, hit_count_o unchanged, success still recorded.
REQ-026 Full FIFO with simultaneous push and pop: both occur, no overflow.
REQ-027 Empty FIFO with push: nonce_valid_o rises next cycle; no same-cycle bypass.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated entry.
REQ-029 Pops SHALL proceed in every FSM state; FIFO contents persist across REPORT and IDLE until popped or flushed.
REQ-030 nonce_o SHALL hold stable while nonce_valid_o && !nonce_ready_i.

Reset
REQ-031 On rst: FSM=IDLE, FIFO empty, result_valid_o=0, success_o=0, nonce_valid_o=0, nonce_o=0, overflow_o=0, hit_count_o=0.
REQ-032 rst mid-sweep SHALL discard all in-flight state; inputs in the rst cycle are ignored.

Configuration
REQ-033 Macro NONCE_COLLECTOR_DEDUP_EN defined: a hit whose nonce equals the last accepted nonce of the current sweep is discarded (no push, no count, no overflow).
REQ-034 Macro undefined: every hit is treated as new; no comparator or last-nonce register exists.

Structure
REQ-035 bcminer_pkg SHALL hold nonce_t (32-bit) and the collector state enum.
REQ-036 FIFO SHALL be a sub-module nonce_fifo (parameter DEPTH, width 32, push/pop/flush, full/empty).

Verification
REQ-037 NUM_CORES=10: newblock beat, hit at core 3 count 0x5, done -> nonce_o=0x00000053, result_valid_o pulse, success_o=1, hit_count_o=1.
REQ-038 FIFO_DEPTH=8, ready low, 10 hits in one sweep -> 8 entries held, overflow_o=1, hit_count_o=8, success_o=1.
REQ-039 Full FIFO, ready high, hit each cycle -> no overflow, output order equals input order across pointer wrap.
REQ-040 newblock mid-sweep with 3 entries queued -> nonce_valid_o=0 next cycle, no result_valid_o, counters cleared.
REQ-041 DEDUP_EN: same nonce hit twice consecutively -> one entry, hit_count_o=1; without macro -> two entries.
REQ-042 rst asserted with hits and done pending -> all outputs 0 next cycle, no result_valid_o.
